// File: rtl/mux16_merge.sv
// Two-source to one-sink stream merger with round-robin arbitration,
// burst locking on the granted source and a registered output stage.
module mux16_merge #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state;
    logic   rr_last;
    logic   space;
    logic   grant_a;
    logic   grant_b;
    logic   a_acc;
    logic   b_acc;

    assign space = ~out_valid | out_ready;

    // A locked source keeps its grant even while its valid is low.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || rr_last)) begin
                    grant_a = 1'b1;
                end else if (b_valid) begin
                    grant_b = 1'b1;
                end
            end
            LOCK_A:  grant_a = 1'b1;
            LOCK_B:  grant_b = 1'b1;
            default: begin
                grant_a = 1'b0;
                grant_b = 1'b0;
            end
        endcase
    end

    assign a_ready = rst_n & grant_a & space;
    assign b_ready = rst_n & grant_b & space;
    assign a_acc   = a_valid & a_ready;
    assign b_acc   = b_valid & b_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (a_acc) begin
            out_data  <= a_data;
            out_sel   <= 1'b0;
            out_last  <= a_last;
            out_valid <= 1'b1;
        end else if (b_acc) begin
            out_data  <= b_data;
            out_sel   <= 1'b1;
            out_last  <= b_last;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // rr_last starts at b so that a wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_last <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (a_acc) begin
                        rr_last <= 1'b0;
                        state   <= a_last ? IDLE : LOCK_A;
                    end else if (b_acc) begin
                        rr_last <= 1'b1;
                        state   <= b_last ? IDLE : LOCK_B;
                    end
                end
                LOCK_A: begin
                    if (a_acc && a_last) begin
                        state <= IDLE;
                    end
                end
                LOCK_B: begin
                    if (b_acc && b_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
